fifo_slot_ctrl: RTL
===================

# fifo_slot_ctrl

Control stage directly upstream of the FIFO index map. It accepts push/pop requests from the router input port, and allocates a free storage slot on each push. It writes that slot number into the index map at the tail pointer, reads the head entry back on each pop, and frees the popped slot. It generates every control and address signal the index map consumes (`write_en`, `waddr`, `wdata`, `read_en`, `raddr`) and keeps occupancy, full/empty and sticky error state.

## Interface
Parameters:
- `DEPTH`, 3: number of entries in the order queue and number of storage slots; need not be a power of two.
- `PTR_SZ`, 2: pointer and slot-index width; ceil(log2(DEPTH)) ≤ PTR_SZ.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `push`  in  1  request to enqueue one entry.
- `push_ready`  out  1  push accepted this cycle; equals `!full`.
- `alloc_slot`  out  PTR_SZ  slot granted to an accepted push; equal to `wdata`.
- `pop`  in  1  request to dequeue one entry.
- `pop_ready`  out  1  pop accepted this cycle; equals `!empty`.
- `pop_slot`  out  PTR_SZ  slot released by an accepted pop; equal to `map_rdata`.
- `write_en`  out  1  index-map write strobe.
- `waddr`  out  PTR_SZ  index-map write address (tail).
- `wdata`  out  PTR_SZ  index-map write data (allocated slot).
- `read_en`  out  1  index-map read strobe.
- `raddr`  out  PTR_SZ  index-map read address (head).
- `map_rdata`  in  PTR_SZ  index-map read data.
- `count`  out  PTR_SZ+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky; set by a push while full.
- `underflow`  out  1  sticky; set by a pop while empty.

## Operation
- **State registers:**
  - `head` and `tail` pointers (PTR_SZ bits each).
  - `count`.
  - `busy[DEPTH-1:0]` slot bitmap.
  - `overflow` and `underflow` flags.
- **Accepted push** (`push & !full`):
  - Combinationally, `write_en`=1, `waddr`=`tail`, and `wdata`=`alloc_slot`=lowest index i with `busy[i]`=0.
  - At the clock edge, `busy[alloc_slot]` is set and `tail` advances.
- **Accepted pop** (`pop & !empty`):
  - Combinationally, `read_en`=1, `raddr`=`head`, and `pop_slot`=`map_rdata`.
  - At the clock edge, `busy[pop_slot]` is cleared and `head` advances.
- **Pointer advance:** a pointer advances as `(p == DEPTH-1) ? 0 : p+1`. It never takes a value ≥ DEPTH.
- **Count update:** `count` increments on push-only, decrements on pop-only, and holds when both or neither are accepted.
- **Simultaneous push and pop:**
  - When `full`: only the pop is accepted. `overflow` is set because the push was rejected while full.
  - When `empty`: only the push is accepted. `underflow` is set.
  - Otherwise both are accepted and `count` is unchanged. A slot freed in a cycle is not reallocated in that same cycle.
- **Rejected requests:** no strobe is issued and no state changes, apart from the sticky flag.
- **Sticky flags:** cleared only by reset.
- **Inactive outputs:** when a strobe is 0, its address and data outputs still show `tail`/`head`/the lowest free slot. Consumers qualify them with the strobe.
- **Invariant:** popcount(`busy`) == `count` at every edge. Violating it is a design error and is asserted in simulation.

## Timing
- **Reset** (`rst_n`=0, asynchronous):
  - `head`=`tail`=0, `count`=0, `busy`=0, `overflow`=`underflow`=0.
  - Hence `empty`=1, `full`=0, `push_ready`=1, `pop_ready`=0, `write_en`=`read_en`=0, `alloc_slot`=`wdata`=0.
- **Strobes and addresses:** `write_en`, `read_en`, `waddr`, `raddr`, `wdata`, `alloc_slot`, `push_ready` and `pop_ready` are combinational from the request inputs and registered state, with zero latency.
- **Pop path:** `pop_slot` follows `map_rdata` combinationally in the same cycle.
- **Status outputs:** `count`, `full`, `empty` and the flags are registered and update one edge after acceptance.
- **Reset mid-operation:** all state returns to the reset values immediately. Index-map contents are not cleared and are don't-care.

## Structure
- **Shared package** (`fifo_pkg`):
  - `ptr_next(p, DEPTH)` wrap function.
  - Occupancy-width constant `PTR_SZ+1`.
  - These are shared with the index map and the FIFO memory wrapper.
- **Sub-module:** `slot_prio_enc`, parameterised by DEPTH/PTR_SZ. It is a lowest-zero priority encoder on `busy`, with a `none_free` output used only for the assertion.

## Test plan
- **Reset then three pushes** (DEPTH=3), feeding back `map_rdata` from a behavioural map:
  - `wdata` = 0, 1, 2 and `waddr` = 0, 1, 2.
  - After the third push, `count`=3, `full`=1 and `push_ready`=0.
- **Fourth push while full:** no `write_en`, `count` stays 3, and `overflow`=1 and stays 1 after a later successful pop.
- **Three pops from full:** `raddr` = 0, 1, 2 and `pop_slot` = 0, 1, 2, then `empty`=1. A further pop sets `underflow`=1 with no `read_en`.
- **Wrap and slot reuse:**
  - Start from push×3 then pop×2, which frees slots 0 and 1; then push×2.
  - Expected: `waddr` = 0, 1 (wrapped), `wdata` = 0, 1, and `head`=2.
  - Follow-up pops return slots 2, 0, 1.
- **Simultaneous push and pop at count=1:** `write_en`=`read_en`=1, `count` stays 1, and the new slot ≠ the slot being freed. The same stimulus while empty gives a push only, `count`=1, `underflow`=1.
- **Reset mid-operation:** assert `rst_n`=0 asynchronously at count=2 between edges. All outputs take their reset values immediately, and the next push writes `waddr`=0, `wdata`=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the FIFO slot controller, the index map and the FIFO
// memory wrapper.
//   ptr_next()  - circular pointer advance that also works for non power-of-two depths
//   cnt_width() - occupancy counter width for a given pointer width (PTR_SZ+1)
//   op_e        - per-cycle operation class (which of push/pop were accepted)
package fifo_pkg;

  localparam int PTR_SZ_DEFAULT = 2;
  localparam int CNT_SZ         = PTR_SZ_DEFAULT + 1;

  // The counter must hold DEPTH itself, so it needs one bit more than a pointer.
  function automatic int cnt_width(input int ptr_sz);
    return ptr_sz + 1;
  endfunction

  // Wraps explicitly at depth-1 so a pointer never takes a value >= depth.
  function automatic int ptr_next(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

  // Encoding is {push_accepted, pop_accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/fifo_slot_ctrl_if.sv
// fifo_slot_ctrl_if
// Bundles the request port of the router and the index-map control port of
// the slot controller.
//   master modport : requester / index-map side (drives push, pop, map_rdata)
//   slave modport  : slot controller side (drives strobes, addresses, status)
interface fifo_slot_ctrl_if
  import fifo_pkg::*;
#(
  parameter int PTR_SZ = 2
);

  logic                           push;
  logic                           push_ready;
  logic [PTR_SZ-1:0]              alloc_slot;
  logic                           pop;
  logic                           pop_ready;
  logic [PTR_SZ-1:0]              pop_slot;
  logic                           write_en;
  logic [PTR_SZ-1:0]              waddr;
  logic [PTR_SZ-1:0]              wdata;
  logic                           read_en;
  logic [PTR_SZ-1:0]              raddr;
  logic [PTR_SZ-1:0]              map_rdata;
  logic [cnt_width(PTR_SZ)-1:0]   count;
  logic                           full;
  logic                           empty;
  logic                           overflow;
  logic                           underflow;

  modport master (
    output push, pop, map_rdata,
    input  push_ready, alloc_slot, pop_ready, pop_slot,
    input  write_en, waddr, wdata, read_en, raddr,
    input  count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, map_rdata,
    output push_ready, alloc_slot, pop_ready, pop_slot,
    output write_en, waddr, wdata, read_en, raddr,
    output count, full, empty, overflow, underflow
  );

endinterface

// File: rtl/slot_prio_enc.sv
// slot_prio_enc
// Lowest-zero priority encoder over the slot busy bitmap.
//   busy      in  DEPTH   slot occupancy bitmap
//   slot      out PTR_SZ  lowest index whose busy bit is 0 (0 when none is free)
//   none_free out 1       every slot is busy
module slot_prio_enc #(
  parameter int DEPTH  = 3,
  parameter int PTR_SZ = 2
) (
  input  logic [DEPTH-1:0]  busy,
  output logic [PTR_SZ-1:0] slot,
  output logic              none_free
);

  // Scan from the top down so the last hit, i.e. the lowest free index, wins.
  always_comb begin
    slot      = '0;
    none_free = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        slot      = PTR_SZ'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fifo_slot_ctrl.sv
// fifo_slot_ctrl
// Control stage upstream of the FIFO index map. Allocates the lowest free
// storage slot on each accepted push and writes it into the map at the tail;
// reads the head entry on each accepted pop and frees that slot. Keeps
// occupancy, full/empty and sticky overflow/underflow state.
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset
//   bus   slave modport of fifo_slot_ctrl_if (requests, map control, status)
module fifo_slot_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int PTR_SZ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_slot_ctrl_if.slave  bus
);

  localparam int CW = cnt_width(PTR_SZ);

  logic [PTR_SZ-1:0] head_q, head_d;
  logic [PTR_SZ-1:0] tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              full;
  logic              empty;
  logic              push_acc;
  logic              pop_acc;
  logic [PTR_SZ-1:0] free_slot;
  logic              none_free;
  op_e               op;

  // Allocation looks at the registered bitmap, so a slot freed this cycle
  // cannot be handed out again until the next cycle.
  slot_prio_enc #(
    .DEPTH  (DEPTH),
    .PTR_SZ (PTR_SZ)
  ) u_slot_prio_enc (
    .busy      (busy_q),
    .slot      (free_slot),
    .none_free (none_free)
  );

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_acc = bus.push & ~full;
  assign pop_acc  = bus.pop & ~empty;
  assign op       = op_e'({push_acc, pop_acc});

  assign bus.push_ready = ~full;
  assign bus.pop_ready  = ~empty;
  assign bus.write_en   = push_acc;
  assign bus.waddr      = tail_q;
  assign bus.wdata      = free_slot;
  assign bus.alloc_slot = free_slot;
  assign bus.read_en    = pop_acc;
  assign bus.raddr      = head_q;
  assign bus.pop_slot   = bus.map_rdata;
  assign bus.count      = count_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;

  // Sticky flags see the raw request, since the error is a request arriving
  // while the queue cannot accept it.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    busy_d      = busy_q;
    overflow_d  = overflow_q | (bus.push & full);
    underflow_d = underflow_q | (bus.pop & empty);

    if (pop_acc) begin
      head_d = PTR_SZ'(ptr_next(int'(head_q), DEPTH));
      if (int'(bus.map_rdata) < DEPTH) begin
        busy_d[bus.map_rdata] = 1'b0;
      end
    end

    if (push_acc) begin
      tail_d            = PTR_SZ'(ptr_next(int'(tail_q), DEPTH));
      busy_d[free_slot] = 1'b1;
    end

    case (op)
      OP_PUSH: count_d = count_q + CW'(1);
      OP_POP:  count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Every occupied queue entry owns exactly one busy slot.
  a_busy_matches_count : assert property (
    @(posedge clk) disable iff (!rst_n) $countones(busy_q) == int'(count_q)
  );

  // An accepted push must always find a free slot.
  a_alloc_has_slot : assert property (
    @(posedge clk) disable iff (!rst_n) push_acc |-> !none_free
  );

endmodule
